// File: rtl/ssp_rx_if.sv
// Serial-in and processor-read signals of the SSP receiver.
// Grouped so the receiver and its driver share one bundle.
interface ssp_rx_if #(
  parameter int DATA_W = 8
);
  logic              SSPCLKIN;
  logic              SSPFSSIN;
  logic              SSPRXD;
  logic              PSEL;
  logic              PWRITE;
  logic [DATA_W-1:0] PRDATA;
  logic              SSPRXINTR;

  modport slave (
    input  SSPCLKIN, SSPFSSIN, SSPRXD, PSEL, PWRITE,
    output PRDATA, SSPRXINTR
  );

  modport master (
    output SSPCLKIN, SSPFSSIN, SSPRXD, PSEL, PWRITE,
    input  PRDATA, SSPRXINTR
  );
endinterface

// File: rtl/ssp_rx.sv
// SSP receive path: TI-style frame deserialiser feeding a small receive FIFO.
// Everything runs on PCLK; SSPCLKIN is synchronous, so falls are found by edge detect.
module ssp_rx #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic    PCLK,
  input  logic    CLEAR_B,
  ssp_rx_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state_q, state_d;
  logic              clk_d;
  logic              fall;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-2:0] shreg_q, shreg_d;
  logic              vld_p0;
  logic [DATA_W-1:0] word_p0;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [LVL_W-1:0]  count;
  logic              pop;
  logic              wr_en;

  assign fall = clk_d & ~bus.SSPCLKIN;
  // Only DATA_W-1 bits are held; the final bit goes straight into the word.
  assign word_p0 = {shreg_q, bus.SSPRXD};

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      clk_d   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      clk_d   <= bus.SSPCLKIN;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    vld_p0  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall && bus.SSPFSSIN) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (fall) begin
          shreg_d = word_p0[DATA_W-2:0];
          if (cnt_q == LAST_BIT) begin
            vld_p0  = 1'b1;
            cnt_d   = '0;
            state_d = bus.SSPFSSIN ? SHIFT : IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- stage p0 -> FIFO: a push into a full FIFO only lands if a pop frees a slot
  assign pop   = bus.PSEL & ~bus.PWRITE & (count != '0);
  assign wr_en = vld_p0 & ((count != FULL_LVL) | pop);

  always_ff @(posedge PCLK) begin
    if (wr_en) mem[wr_ptr] <= word_p0;
  end

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({wr_en, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.PRDATA    = (count != '0) ? mem[rd_ptr] : '0;
  assign bus.SSPRXINTR = (count == FULL_LVL);
endmodule
